alu_rs: RTL and testbench

- Reservation station directly upstream of the integer/MUL-DIV ALU in the out-of-order core.
- Buffers dispatched ALU instructions until both source operands are available. Operands come from dispatch or from common-data-bus (CDB) broadcasts.
- Issues at most one ready instruction per cycle, oldest first, as a registered bundle that drives the ALU operand, decode and valid inputs directly.
- The ALU never stalls, so there is no issue backpressure.

---
 rtl/alu_rs_pkg.sv | 35 +++
 rtl/alu_rs_if.sv | 59 +++++
 rtl/alu_rs_select.sv | 30 +++
 rtl/alu_rs.sv | 193 +++++++++++++++++++
 tb/tb_alu_rs.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs_pkg
// Description : Opcode/funct3 encodings shared by the ALU, the decoder and the
//               ALU reservation station, plus the per-entry decode bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_rs_pkg;

    localparam logic [6:0] c_op_rtype  = 7'h33;
    localparam logic [6:0] c_op_itype  = 7'h13;
    localparam logic [6:0] c_op_lui    = 7'h37;
    localparam logic [6:0] c_op_auipc  = 7'h17;
    localparam logic [6:0] c_op_branch = 7'h63;

    localparam logic [5:0] c_f3_add  = 6'd0;
    localparam logic [5:0] c_f3_sll  = 6'd1;
    localparam logic [5:0] c_f3_slt  = 6'd2;
    localparam logic [5:0] c_f3_sltu = 6'd3;
    localparam logic [5:0] c_f3_xor  = 6'd4;
    localparam logic [5:0] c_f3_sr   = 6'd5;
    localparam logic [5:0] c_f3_or   = 6'd6;
    localparam logic [5:0] c_f3_and  = 6'd7;

    // Fixed-width decode fields carried unchanged from dispatch to the ALU.
    typedef struct packed {
        logic [6:0] opcode;
        logic [5:0] funct3;
        logic [6:0] funct7;
        logic [4:0] imm;
        logic [6:0] imm_funct;
    } rs_decode_t;

endpackage
`default_nettype wire

// File: rtl/alu_rs_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs_if
// Description : Dispatch, CDB and issue bundle of the ALU reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_rs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 4
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  disp_valid;
    logic                  disp_ready;
    logic [6:0]            disp_opcode;
    logic [5:0]            disp_funct3;
    logic [6:0]            disp_funct7;
    logic [4:0]            disp_imm;
    logic [6:0]            disp_imm_funct;
    logic [ID_WIDTH-1:0]   disp_tag;
    logic                  disp_src1_rdy;
    logic [ID_WIDTH-1:0]   disp_src1_tag;
    logic [DATA_WIDTH-1:0] disp_src1_val;
    logic                  disp_src2_rdy;
    logic [ID_WIDTH-1:0]   disp_src2_tag;
    logic [DATA_WIDTH-1:0] disp_src2_val;
    logic                  cdb_valid;
    logic [ID_WIDTH-1:0]   cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_data;
    logic                  iss_valid;
    logic [6:0]            iss_opcode;
    logic [5:0]            iss_funct3;
    logic [6:0]            iss_funct7;
    logic [4:0]            iss_imm;
    logic [6:0]            iss_imm_funct;
    logic [DATA_WIDTH-1:0] iss_op1;
    logic [DATA_WIDTH-1:0] iss_op2;
    logic [ID_WIDTH-1:0]   iss_tag;
    logic [c_cnt_w-1:0]    count;

    modport master (
        output flush, disp_valid, disp_opcode, disp_funct3, disp_funct7, disp_imm,
               disp_imm_funct, disp_tag, disp_src1_rdy, disp_src1_tag, disp_src1_val,
               disp_src2_rdy, disp_src2_tag, disp_src2_val, cdb_valid, cdb_tag, cdb_data,
        input  disp_ready, iss_valid, iss_opcode, iss_funct3, iss_funct7, iss_imm,
               iss_imm_funct, iss_op1, iss_op2, iss_tag, count
    );

    modport slave (
        input  flush, disp_valid, disp_opcode, disp_funct3, disp_funct7, disp_imm,
               disp_imm_funct, disp_tag, disp_src1_rdy, disp_src1_tag, disp_src1_val,
               disp_src2_rdy, disp_src2_tag, disp_src2_val, cdb_valid, cdb_tag, cdb_data,
        output disp_ready, iss_valid, iss_opcode, iss_funct3, iss_funct7, iss_imm,
               iss_imm_funct, iss_op1, iss_op2, iss_tag, count
    );
endinterface
`default_nettype wire

// File: rtl/alu_rs_select.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs_select
// Description : Lowest-index priority picker: one-hot grant, index, any_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rs_select #(
    parameter int DEPTH = 4
) (
    input  wire logic [DEPTH-1:0]         i_req,
    output logic      [DEPTH-1:0]         o_grant,
    output logic      [$clog2(DEPTH)-1:0] o_idx,
    output logic                          o_any
);
    localparam int c_idx_w = $clog2(DEPTH);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_req[i] && !o_any) begin
                o_grant[i] = 1'b1;
                o_idx      = c_idx_w'(i);
                o_any      = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs
// Description : Collapsing-queue reservation station feeding the integer ALU;
//               oldest-ready-first issue into registered operand/decode outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 4
) (
    input wire logic clk,
    input wire logic reset,
    alu_rs_if.slave  bus
);
    localparam int                 c_idx_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef struct packed {
        logic                  valid;
        rs_decode_t            dec;
        logic [ID_WIDTH-1:0]   tag;
        logic                  src1_rdy;
        logic [ID_WIDTH-1:0]   src1_tag;
        logic [DATA_WIDTH-1:0] src1_val;
        logic                  src2_rdy;
        logic [ID_WIDTH-1:0]   src2_tag;
        logic [DATA_WIDTH-1:0] src2_val;
    } entry_t;

    entry_t                r_entry [DEPTH];
    entry_t                w_woken [DEPTH];
    entry_t                w_next  [DEPTH];
    entry_t                w_new;
    logic [DEPTH-1:0]      w_req;
    logic [DEPTH-1:0]      w_grant;
    logic [c_idx_w-1:0]    w_idx;
    logic                  w_any;
    logic                  w_disp_rdy;
    logic                  w_disp_acc;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_cnt_w-1:0]    w_wr_idx;
    logic [c_cnt_w-1:0]    w_count_nxt;
    rs_decode_t            w_sel_dec;
    logic [ID_WIDTH-1:0]   w_sel_tag;
    logic [DATA_WIDTH-1:0] w_sel_op1;
    logic [DATA_WIDTH-1:0] w_sel_op2;

    logic                  r_iss_valid;
    rs_decode_t            r_iss_dec;
    logic [ID_WIDTH-1:0]   r_iss_tag;
    logic [DATA_WIDTH-1:0] r_iss_op1;
    logic [DATA_WIDTH-1:0] r_iss_op2;

    function automatic logic cdb_hit(input logic rdy, input logic [ID_WIDTH-1:0] tag,
                                     input logic cv, input logic [ID_WIDTH-1:0] ct);
        return !rdy && cv && (tag == ct);
    endfunction

    // Slot availability is judged on registered occupancy only.
    assign w_disp_rdy  = (r_count < c_depth);
    assign w_disp_acc  = bus.disp_valid && w_disp_rdy;
    assign w_wr_idx    = r_count - c_cnt_w'(w_any);
    assign w_count_nxt = r_count + c_cnt_w'(w_disp_acc) - c_cnt_w'(w_any);

    alu_rs_select #(.DEPTH(DEPTH)) u_select (
        .i_req   (w_req),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_req     = '0;
        w_sel_dec = '0;
        w_sel_tag = '0;
        w_sel_op1 = '0;
        w_sel_op2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_req[i] = r_entry[i].valid && r_entry[i].src1_rdy && r_entry[i].src2_rdy;
            if (w_grant[i]) begin
                w_sel_dec = r_entry[i].dec;
                w_sel_tag = r_entry[i].tag;
                w_sel_op1 = r_entry[i].src1_val;
                w_sel_op2 = r_entry[i].src2_val;
            end
        end
    end

    // Incoming entry, with same-cycle CDB capture for sources not yet ready.
    always_comb begin
        w_new               = '0;
        w_new.valid         = 1'b1;
        w_new.dec.opcode    = bus.disp_opcode;
        w_new.dec.funct3    = bus.disp_funct3;
        w_new.dec.funct7    = bus.disp_funct7;
        w_new.dec.imm       = bus.disp_imm;
        w_new.dec.imm_funct = bus.disp_imm_funct;
        w_new.tag           = bus.disp_tag;
        w_new.src1_tag      = bus.disp_src1_tag;
        w_new.src2_tag      = bus.disp_src2_tag;
        w_new.src1_rdy      = bus.disp_src1_rdy;
        w_new.src1_val      = bus.disp_src1_val;
        w_new.src2_rdy      = bus.disp_src2_rdy;
        w_new.src2_val      = bus.disp_src2_val;
        if (cdb_hit(bus.disp_src1_rdy, bus.disp_src1_tag, bus.cdb_valid, bus.cdb_tag)) begin
            w_new.src1_rdy = 1'b1;
            w_new.src1_val = bus.cdb_data;
        end
        if (cdb_hit(bus.disp_src2_rdy, bus.disp_src2_tag, bus.cdb_valid, bus.cdb_tag)) begin
            w_new.src2_rdy = 1'b1;
            w_new.src2_val = bus.cdb_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_woken[i] = r_entry[i];
            if (r_entry[i].valid &&
                cdb_hit(r_entry[i].src1_rdy, r_entry[i].src1_tag, bus.cdb_valid, bus.cdb_tag)) begin
                w_woken[i].src1_rdy = 1'b1;
                w_woken[i].src1_val = bus.cdb_data;
            end
            if (r_entry[i].valid &&
                cdb_hit(r_entry[i].src2_rdy, r_entry[i].src2_tag, bus.cdb_valid, bus.cdb_tag)) begin
                w_woken[i].src2_rdy = 1'b1;
                w_woken[i].src2_val = bus.cdb_data;
            end
        end
    end

    // Collapse above the issued slot, then drop the new entry at the tail.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_next[i] = (w_any && i >= int'(w_idx)) ? w_woken[i+1] : w_woken[i];
        end
        w_next[DEPTH-1] = w_any ? '0 : w_woken[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (w_disp_acc && w_wr_idx == c_cnt_w'(i)) begin
                w_next[i] = w_new;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_count     <= '0;
            r_iss_valid <= 1'b0;
            r_iss_dec   <= '0;
            r_iss_tag   <= '0;
            r_iss_op1   <= '0;
            r_iss_op2   <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i].valid <= 1'b0;
            end
            r_count     <= '0;
            r_iss_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_next[i];
            end
            r_count     <= w_count_nxt;
            r_iss_valid <= w_any;
            if (w_any) begin
                r_iss_dec <= w_sel_dec;
                r_iss_tag <= w_sel_tag;
                r_iss_op1 <= w_sel_op1;
                r_iss_op2 <= w_sel_op2;
            end
        end
    end

    assign bus.disp_ready    = w_disp_rdy;
    assign bus.count         = r_count;
    assign bus.iss_valid     = r_iss_valid;
    assign bus.iss_opcode    = r_iss_dec.opcode;
    assign bus.iss_funct3    = r_iss_dec.funct3;
    assign bus.iss_funct7    = r_iss_dec.funct7;
    assign bus.iss_imm       = r_iss_dec.imm;
    assign bus.iss_imm_funct = r_iss_dec.imm_funct;
    assign bus.iss_tag       = r_iss_tag;
    assign bus.iss_op1       = r_iss_op1;
    assign bus.iss_op2       = r_iss_op2;
endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rs
// Description : Directed self-checking bench for the ALU reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rs;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int DEPTH      = 4;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_rs_if #(.DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH)) bus ();

    alu_rs #(.DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.flush          = 1'b0;
        bus.disp_valid     = 1'b0;
        bus.disp_opcode    = 7'h0;
        bus.disp_funct3    = 6'h0;
        bus.disp_funct7    = 7'h0;
        bus.disp_imm       = 5'h0;
        bus.disp_imm_funct = 7'h0;
        bus.disp_tag       = '0;
        bus.disp_src1_rdy  = 1'b0;
        bus.disp_src1_tag  = '0;
        bus.disp_src1_val  = '0;
        bus.disp_src2_rdy  = 1'b0;
        bus.disp_src2_tag  = '0;
        bus.disp_src2_val  = '0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_tag        = '0;
        bus.cdb_data       = '0;
    endtask

    task automatic drive_disp(input logic [3:0] tag,
                              input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                              input logic r2, input logic [3:0] t2, input logic [31:0] v2);
        bus.disp_valid    = 1'b1;
        bus.disp_opcode   = 7'h33;
        bus.disp_funct3   = 6'h0;
        bus.disp_funct7   = 7'h0;
        bus.disp_tag      = tag;
        bus.disp_src1_rdy = r1;
        bus.disp_src1_tag = t1;
        bus.disp_src1_val = v1;
        bus.disp_src2_rdy = r2;
        bus.disp_src2_tag = t2;
        bus.disp_src2_val = v2;
    endtask

    task automatic drive_cdb(input logic [3:0] tag, input logic [31:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check_val("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
        check_val("rst_count", 64'(bus.count), 64'd0);
        check_val("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        check_val("rst_iss_op1", 64'(bus.iss_op1), 64'd0);
        tick();

        // Ready dispatch: issue in the second cycle after dispatch.
        drive_disp(4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
        tick();
        clear_inputs();
        check_val("t1_count_written", 64'(bus.count), 64'd1);
        check_val("t1_not_yet", 64'(bus.iss_valid), 64'd0);
        tick();
        check_val("t1_iss_valid", 64'(bus.iss_valid), 64'd1);
        check_val("t1_op1", 64'(bus.iss_op1), 64'd5);
        check_val("t1_op2", 64'(bus.iss_op2), 64'd7);
        check_val("t1_tag", 64'(bus.iss_tag), 64'd3);
        check_val("t1_opcode", 64'(bus.iss_opcode), 64'h33);
        check_val("t1_count_after", 64'(bus.count), 64'd0);
        tick();
        check_val("t1_empty_valid", 64'(bus.iss_valid), 64'd0);
        check_val("t1_hold_op1", 64'(bus.iss_op1), 64'd5);

        // CDB wakeup.
        drive_disp(4'd5, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd2);
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t2_waiting", 64'(bus.iss_valid), 64'd0);
        end
        drive_cdb(4'd9, 32'h100);
        tick();
        clear_inputs();
        check_val("t2_after_E", 64'(bus.iss_valid), 64'd0);
        check_val("t2_count_E", 64'(bus.count), 64'd1);
        tick();
        check_val("t2_iss_valid", 64'(bus.iss_valid), 64'd1);
        check_val("t2_op1", 64'(bus.iss_op1), 64'h100);
        check_val("t2_op2", 64'(bus.iss_op2), 64'd2);
        check_val("t2_tag", 64'(bus.iss_tag), 64'd5);
        tick();

        // Dispatch bypass from a same-cycle broadcast.
        drive_disp(4'd6, 1'b1, 4'd0, 32'h11, 1'b0, 4'd4, 32'd0);
        bus.disp_funct7 = 7'h20;
        drive_cdb(4'd4, 32'hAB);
        tick();
        clear_inputs();
        check_val("t3_count", 64'(bus.count), 64'd1);
        tick();
        check_val("t3_iss_valid", 64'(bus.iss_valid), 64'd1);
        check_val("t3_op2", 64'(bus.iss_op2), 64'hAB);
        check_val("t3_op1", 64'(bus.iss_op1), 64'h11);
        check_val("t3_funct7", 64'(bus.iss_funct7), 64'h20);
        tick();

        // Fill to DEPTH, then drop dispatches while full (also during an issue).
        for (int k = 1; k <= 4; k++) begin
            drive_disp(4'(k), 1'b0, 4'd15, 32'd0, 1'b1, 4'd0, 32'(k * 16));
            tick();
        end
        clear_inputs();
        check_val("t4_count_full", 64'(bus.count), 64'd4);
        check_val("t4_disp_ready", 64'(bus.disp_ready), 64'd0);
        drive_cdb(4'd15, 32'hF00);
        drive_disp(4'd5, 1'b1, 4'd0, 32'h5, 1'b1, 4'd0, 32'h5);
        tick();
        bus.cdb_valid = 1'b0;
        check_val("t4_drop_count", 64'(bus.count), 64'd4);
        check_val("t4_no_issue_yet", 64'(bus.iss_valid), 64'd0);
        tick();
        clear_inputs();
        check_val("t4_tag1", 64'(bus.iss_tag), 64'd1);
        check_val("t4_op1", 64'(bus.iss_op1), 64'hF00);
        check_val("t4_op2", 64'(bus.iss_op2), 64'h10);
        check_val("t4_drop_on_issue", 64'(bus.count), 64'd3);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check_val("t4_order_valid", 64'(bus.iss_valid), 64'd1);
            check_val("t4_order_tag", 64'(bus.iss_tag), 64'(k));
            check_val("t4_order_count", 64'(bus.count), 64'(4 - k));
        end
        tick();
        check_val("t4_drained", 64'(bus.iss_valid), 64'd0);

        // Out-of-order ready, with dispatch collapsing into the issued slot.
        drive_disp(4'd8, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd2);
        tick();
        drive_disp(4'd9, 1'b1, 4'd0, 32'h21, 1'b1, 4'd0, 32'h22);
        tick();
        check_val("t5_count2", 64'(bus.count), 64'd2);
        drive_disp(4'd10, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd3);
        tick();
        clear_inputs();
        check_val("t5_first_tag", 64'(bus.iss_tag), 64'd9);
        check_val("t5_first_op1", 64'(bus.iss_op1), 64'h21);
        check_val("t5_collapse_count", 64'(bus.count), 64'd2);
        drive_cdb(4'd7, 32'h77);
        tick();
        clear_inputs();
        check_val("t5_wake_no_issue", 64'(bus.iss_valid), 64'd0);
        tick();
        check_val("t5_e0_tag", 64'(bus.iss_tag), 64'd8);
        check_val("t5_e0_op1", 64'(bus.iss_op1), 64'h77);
        check_val("t5_e0_count", 64'(bus.count), 64'd1);
        tick();
        check_val("t5_e2_tag", 64'(bus.iss_tag), 64'd10);
        check_val("t5_e2_op2", 64'(bus.iss_op2), 64'd3);
        check_val("t5_e2_count", 64'(bus.count), 64'd0);
        tick();

        // Flush overrides a same-cycle dispatch and wakeup.
        for (int k = 1; k <= 3; k++) begin
            drive_disp(4'(k), 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'd1);
            tick();
        end
        clear_inputs();
        check_val("t6_count3", 64'(bus.count), 64'd3);
        bus.flush = 1'b1;
        drive_disp(4'd4, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
        drive_cdb(4'd12, 32'hC);
        tick();
        clear_inputs();
        check_val("t6_flush_count", 64'(bus.count), 64'd0);
        check_val("t6_flush_valid", 64'(bus.iss_valid), 64'd0);
        check_val("t6_flush_ready", 64'(bus.disp_ready), 64'd1);
        drive_cdb(4'd12, 32'hC);
        tick();
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("t6_nothing_issues", 64'(bus.iss_valid), 64'd0);
        end

        // Asynchronous reset clears the issue register between edges.
        drive_disp(4'd2, 1'b1, 4'd0, 32'h55, 1'b1, 4'd0, 32'h66);
        tick();
        clear_inputs();
        tick();
        check_val("t6_pre_reset_valid", 64'(bus.iss_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_async_valid", 64'(bus.iss_valid), 64'd0);
        check_val("t6_async_op1", 64'(bus.iss_op1), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        check_val("t6_post_ready", 64'(bus.disp_ready), 64'd1);
        check_val("t6_post_count", 64'(bus.count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
